// File: rtl/cdb_broadcast_arbiter.sv
// Common data bus arbiter: one hold register per result source, LSQ sources by fixed
// priority then the rest round-robin, winners broadcast through registered CDB ports.
module cdb_broadcast_arbiter #(
   parameter int NUM_SRC   = 6,
   parameter int NUM_CDB   = 2,
   parameter int NUM_FIXED = 2,
   parameter int DATA_W    = 64,
   parameter int PRN_W     = 6,
   parameter int ROB_W     = 5,
   parameter int TID_W     = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC*DATA_W-1:0]   src_result,
   input  logic [NUM_SRC*PRN_W-1:0]    src_prn,
   input  logic [NUM_SRC*ROB_W-1:0]    src_rob,
   input  logic [NUM_SRC*TID_W-1:0]    src_tid,
   input  logic [NUM_SRC-1:0]          src_mispredict,
   input  logic [(2**TID_W)-1:0]       squash,
   output logic [NUM_SRC-1:0]          src_ready,
   output logic [NUM_CDB-1:0]          cdb_valid,
   output logic [NUM_CDB*DATA_W-1:0]   cdb_result,
   output logic [NUM_CDB*PRN_W-1:0]    cdb_prn,
   output logic [NUM_CDB*ROB_W-1:0]    cdb_rob,
   output logic [NUM_CDB*TID_W-1:0]    cdb_tid,
   output logic [NUM_CDB-1:0]          cdb_mispredict
);

   localparam int PTR_W = $clog2(NUM_SRC + 1);

   logic [NUM_SRC-1:0] hold_valid;
   logic [DATA_W-1:0]  hold_result [NUM_SRC];
   logic [PRN_W-1:0]   hold_prn    [NUM_SRC];
   logic [ROB_W-1:0]   hold_rob    [NUM_SRC];
   logic [TID_W-1:0]   hold_tid    [NUM_SRC];
   logic [NUM_SRC-1:0] hold_misp;

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_next;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] grant;
   int                 port_of [NUM_SRC];

   logic [NUM_CDB-1:0] sel_valid;
   logic [DATA_W-1:0]  sel_result [NUM_CDB];
   logic [PRN_W-1:0]   sel_prn    [NUM_CDB];
   logic [ROB_W-1:0]   sel_rob    [NUM_CDB];
   logic [TID_W-1:0]   sel_tid    [NUM_CDB];
   logic [NUM_CDB-1:0] sel_misp;

   assign src_ready = ~hold_valid;

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         eligible[i] = hold_valid[i] & ~squash[hold_tid[i]];
      end
   end

   // Pass 0 walks the fixed sources, passes 1 and 2 walk the round-robin sources
   // from rr_ptr to the top and then wrap back from NUM_FIXED.
   always_comb begin
      int  n;
      logic take;
      n       = 0;
      take    = 1'b0;
      grant   = '0;
      rr_next = rr_ptr;
      for (int i = 0; i < NUM_SRC; i++) begin
         port_of[i] = 0;
      end
      for (int pass = 0; pass < 3; pass++) begin
         for (int j = 0; j < NUM_SRC; j++) begin
            take = ((pass == 0) && (j < NUM_FIXED)) ||
                   ((pass == 1) && (j >= NUM_FIXED) && (PTR_W'(j) >= rr_ptr)) ||
                   ((pass == 2) && (j >= NUM_FIXED) && (PTR_W'(j) < rr_ptr));
            if (take && eligible[j] && (n < NUM_CDB)) begin
               grant[j]   = 1'b1;
               port_of[j] = n;
               n          = n + 1;
               if (j >= NUM_FIXED) begin
                  rr_next = (j == NUM_SRC - 1) ? PTR_W'(NUM_FIXED) : PTR_W'(j + 1);
               end
            end
         end
      end
   end

   always_comb begin
      sel_valid = '0;
      sel_misp  = '0;
      for (int p = 0; p < NUM_CDB; p++) begin
         sel_result[p] = '0;
         sel_prn[p]    = '0;
         sel_rob[p]    = '0;
         sel_tid[p]    = '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i] && (port_of[i] == p)) begin
               sel_valid[p]  = 1'b1;
               sel_result[p] = hold_result[i];
               sel_prn[p]    = hold_prn[i];
               sel_rob[p]    = hold_rob[i];
               sel_tid[p]    = hold_tid[i];
               sel_misp[p]   = hold_misp[i];
            end
         end
      end
   end

   // A squashed or granted entry frees its slot; a free slot only refills next cycle
   // because src_ready comes straight from hold_valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid <= '0;
         rr_ptr     <= PTR_W'(NUM_FIXED);
      end else begin
         rr_ptr <= rr_next;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i] || (hold_valid[i] && squash[hold_tid[i]])) begin
               hold_valid[i] <= 1'b0;
            end else if (!hold_valid[i] && src_valid[i] &&
                         !squash[src_tid[i*TID_W +: TID_W]]) begin
               hold_valid[i]  <= 1'b1;
               hold_result[i] <= src_result[i*DATA_W +: DATA_W];
               hold_prn[i]    <= src_prn[i*PRN_W +: PRN_W];
               hold_rob[i]    <= src_rob[i*ROB_W +: ROB_W];
               hold_tid[i]    <= src_tid[i*TID_W +: TID_W];
               hold_misp[i]   <= src_mispredict[i];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cdb_valid      <= '0;
         cdb_result     <= '0;
         cdb_prn        <= '0;
         cdb_rob        <= '0;
         cdb_tid        <= '0;
         cdb_mispredict <= '0;
      end else begin
         cdb_valid      <= sel_valid;
         cdb_mispredict <= sel_misp;
         for (int p = 0; p < NUM_CDB; p++) begin
            cdb_result[p*DATA_W +: DATA_W] <= sel_result[p];
            cdb_prn[p*PRN_W +: PRN_W]      <= sel_prn[p];
            cdb_rob[p*ROB_W +: ROB_W]      <= sel_rob[p];
            cdb_tid[p*TID_W +: TID_W]      <= sel_tid[p];
         end
      end
   end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Bench for cdb_broadcast_arbiter: directed scenarios plus random traffic, all
// checked against a priority-list reference model of the arbitration rules.
module tb_cdb_broadcast_arbiter;

   localparam int NS = 6;
   localparam int NC = 2;
   localparam int NF = 2;
   localparam int DW = 64;
   localparam int PW = 6;
   localparam int RW = 5;
   localparam int TW = 1;
   localparam int NT = 2;
   localparam int PORT_W = 1 + DW + PW + RW + TW + 1;

   logic              clock = 1'b0;
   logic              reset;
   logic [NS-1:0]     src_valid;
   logic [NS*DW-1:0]  src_result;
   logic [NS*PW-1:0]  src_prn;
   logic [NS*RW-1:0]  src_rob;
   logic [NS*TW-1:0]  src_tid;
   logic [NS-1:0]     src_mispredict;
   logic [NT-1:0]     squash;
   logic [NS-1:0]     src_ready;
   logic [NC-1:0]     cdb_valid;
   logic [NC*DW-1:0]  cdb_result;
   logic [NC*PW-1:0]  cdb_prn;
   logic [NC*RW-1:0]  cdb_rob;
   logic [NC*TW-1:0]  cdb_tid;
   logic [NC-1:0]     cdb_mispredict;

   cdb_broadcast_arbiter #(
      .NUM_SRC(NS), .NUM_CDB(NC), .NUM_FIXED(NF), .DATA_W(DW),
      .PRN_W(PW), .ROB_W(RW), .TID_W(TW)
   ) dut (
      .clock(clock), .reset(reset),
      .src_valid(src_valid), .src_result(src_result), .src_prn(src_prn),
      .src_rob(src_rob), .src_tid(src_tid), .src_mispredict(src_mispredict),
      .squash(squash), .src_ready(src_ready),
      .cdb_valid(cdb_valid), .cdb_result(cdb_result), .cdb_prn(cdb_prn),
      .cdb_rob(cdb_rob), .cdb_tid(cdb_tid), .cdb_mispredict(cdb_mispredict)
   );

   always #5 clock = ~clock;

   bit                m_valid  [NS];
   logic [DW-1:0]     m_result [NS];
   logic [PW-1:0]     m_prn    [NS];
   logic [RW-1:0]     m_rob    [NS];
   logic [TW-1:0]     m_tid    [NS];
   bit                m_misp   [NS];
   int                m_rr;
   logic [NC*PORT_W-1:0] exp_bus;
   logic [NC*PORT_W-1:0] obs_bus;
   logic [NS-1:0]     exp_ready;
   int                n_cmp = 0;
   int                n_bad = 0;

   // Reference: list sources in priority order (fixed, then rotation from the
   // pointer), hand bus slots to the first NC live entries, then update holds.
   function automatic void model_edge();
      int order[$];
      bit won [NS];
      int nw;
      int last_rr;
      logic [NC*PORT_W-1:0] nb;
      if (reset) begin
         for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
         m_rr      = NF;
         exp_bus   = '0;
         exp_ready = '1;
         return;
      end
      for (int i = 0; i < NF; i++) order.push_back(i);
      for (int k = 0; k < NS - NF; k++) order.push_back(NF + (m_rr - NF + k) % (NS - NF));
      nb = '0;
      nw = 0;
      last_rr = -1;
      for (int s = 0; s < NS; s++) won[s] = 1'b0;
      foreach (order[x]) begin
         int s;
         s = order[x];
         if (m_valid[s] && !squash[m_tid[s]] && nw < NC) begin
            nb[nw*PORT_W +: PORT_W] = {1'b1, m_result[s], m_prn[s], m_rob[s], m_tid[s], m_misp[s]};
            won[s] = 1'b1;
            nw++;
            if (s >= NF) last_rr = s;
         end
      end
      if (last_rr >= 0) m_rr = (last_rr + 1 == NS) ? NF : last_rr + 1;
      for (int s = 0; s < NS; s++) begin
         if (won[s] || (m_valid[s] && squash[m_tid[s]])) begin
            m_valid[s] = 1'b0;
         end else if (!m_valid[s] && src_valid[s] && !squash[src_tid[s*TW +: TW]]) begin
            m_valid[s]  = 1'b1;
            m_result[s] = src_result[s*DW +: DW];
            m_prn[s]    = src_prn[s*PW +: PW];
            m_rob[s]    = src_rob[s*RW +: RW];
            m_tid[s]    = src_tid[s*TW +: TW];
            m_misp[s]   = src_mispredict[s];
         end
      end
      exp_bus = nb;
      for (int s = 0; s < NS; s++) exp_ready[s] = !m_valid[s];
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
      obs_bus = '0;
      for (int p = 0; p < NC; p++) begin
         if (cdb_valid[p])
            obs_bus[p*PORT_W +: PORT_W] = {1'b1, cdb_result[p*DW +: DW], cdb_prn[p*PW +: PW],
                                           cdb_rob[p*RW +: RW], cdb_tid[p*TW +: TW],
                                           cdb_mispredict[p]};
      end
   endtask

   task automatic clear_inputs();
      reset          = 1'b0;
      src_valid      = '0;
      src_result     = '0;
      src_prn        = '0;
      src_rob        = '0;
      src_tid        = '0;
      src_mispredict = '0;
      squash         = '0;
   endtask

   task automatic offer(input int s, input logic [DW-1:0] r, input logic [PW-1:0] prn,
                        input logic [TW-1:0] tid);
      src_valid[s]           = 1'b1;
      src_result[s*DW +: DW] = r;
      src_prn[s*PW +: PW]    = prn;
      src_rob[s*RW +: RW]    = RW'(s);
      src_tid[s*TW +: TW]    = tid;
      src_mispredict[s]      = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_cmp++;
      if ({cdb_valid, cdb_result, cdb_prn, cdb_rob, cdb_tid, cdb_mispredict} !== '0) begin
         n_bad++;
         $display("[TB] FAIL reset_cdb: got valid=%b result=%h, expected all zero", cdb_valid, cdb_result);
      end
      n_cmp++;
      if (src_ready !== '1) begin
         n_bad++;
         $display("[TB] FAIL reset_ready: got %b expected %b", src_ready, {NS{1'b1}});
      end
   endtask

   task automatic test_single_source();
      do_reset();
      offer(2, 64'd5, 6'd3, 1'b0);
      tick();
      src_valid = '0;
      n_cmp++;
      if (src_ready !== 6'b111011 || cdb_valid !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL single_capture: got ready=%b valid=%b expected 111011/00", src_ready, cdb_valid);
      end
      tick();
      n_cmp++;
      if (cdb_valid !== 2'b01 || cdb_result[DW-1:0] !== 64'd5 || cdb_prn[PW-1:0] !== 6'd3) begin
         n_bad++;
         $display("[TB] FAIL single_bcast: got valid=%b result=%h prn=%0d expected 01/5/3",
                  cdb_valid, cdb_result[DW-1:0], cdb_prn[PW-1:0]);
      end
      n_cmp++;
      if (src_ready !== '1 || obs_bus !== exp_bus) begin
         n_bad++;
         $display("[TB] FAIL single_model: got ready=%b bus=%h expected %b/%h", src_ready, obs_bus, exp_ready, exp_bus);
      end
      tick();
      n_cmp++;
      if (cdb_valid !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL single_oneshot: got valid=%b expected 00", cdb_valid);
      end
   endtask

   task automatic test_full_contention();
      logic [DW-1:0] e0 [3] = '{64'hAAAA, 64'h22, 64'h44};
      logic [DW-1:0] e1 [3] = '{64'hBBBB, 64'h33, 64'h55};
      do_reset();
      offer(0, 64'hAAAA, 6'd10, 1'b0);
      offer(1, 64'hBBBB, 6'd11, 1'b0);
      for (int s = 2; s < NS; s++) offer(s, DW'(s * 17), PW'(12 + s), 1'b0);
      tick();
      src_valid = '0;
      n_cmp++;
      if (src_ready !== '0) begin
         n_bad++;
         $display("[TB] FAIL contention_held: got ready=%b expected 000000", src_ready);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if (cdb_valid !== 2'b11 || cdb_result[DW-1:0] !== e0[c] || cdb_result[2*DW-1:DW] !== e1[c]) begin
            n_bad++;
            $display("[TB] FAIL contention_c%0d: got valid=%b p0=%h p1=%h expected 11/%h/%h",
                     c, cdb_valid, cdb_result[DW-1:0], cdb_result[2*DW-1:DW], e0[c], e1[c]);
         end
         n_cmp++;
         if (obs_bus !== exp_bus) begin
            n_bad++;
            $display("[TB] FAIL contention_model: got %h expected %h", obs_bus, exp_bus);
         end
      end
      tick();
      n_cmp++;
      if (cdb_valid !== 2'b00 || src_ready !== '1) begin
         n_bad++;
         $display("[TB] FAIL contention_drained: got valid=%b ready=%b expected 00/111111", cdb_valid, src_ready);
      end
   endtask

   task automatic test_starvation();
      int rr_seq[$];
      int lsq_cnt;
      int bad_order;
      int model_bad;
      do_reset();
      offer(0, 64'h1000, 6'd1, 1'b0);
      for (int s = 2; s < NS; s++) offer(s, DW'(s), PW'(s), 1'b0);
      lsq_cnt = 0;
      model_bad = 0;
      for (int c = 0; c < 48; c++) begin
         tick();
         if (obs_bus !== exp_bus || src_ready !== exp_ready) model_bad++;
         for (int p = 0; p < NC; p++) begin
            if (cdb_valid[p]) begin
               if (cdb_result[p*DW +: DW] == 64'h1000) lsq_cnt++;
               else rr_seq.push_back(int'(cdb_result[p*DW +: 8]));
            end
         end
      end
      bad_order = 0;
      foreach (rr_seq[k]) if (rr_seq[k] != 2 + (k % 4)) bad_order++;
      n_cmp++;
      if (bad_order != 0 || rr_seq.size() < 40) begin
         n_bad++;
         $display("[TB] FAIL starve_rr: got %0d out-of-order of %0d grants, expected 0 of >=40",
                  bad_order, rr_seq.size());
      end
      n_cmp++;
      if (lsq_cnt != 24) begin
         n_bad++;
         $display("[TB] FAIL starve_lsq: got %0d LSQ0 broadcasts expected 24", lsq_cnt);
      end
      n_cmp++;
      if (model_bad != 0) begin
         n_bad++;
         $display("[TB] FAIL starve_model: got %0d differing cycles expected 0", model_bad);
      end
   endtask

   task automatic test_squash();
      int leaked;
      do_reset();
      offer(2, 64'h200, 6'd2, 1'b0);
      offer(3, 64'h300, 6'd3, 1'b1);
      tick();
      src_valid = '0;
      squash = 2'b01;
      offer(4, 64'h400, 6'd4, 1'b0);
      tick();
      n_cmp++;
      if (cdb_valid !== 2'b01 || cdb_result[DW-1:0] !== 64'h300 || cdb_tid[TW-1:0] !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL squash_other: got valid=%b result=%h tid=%b expected 01/300/1",
                  cdb_valid, cdb_result[DW-1:0], cdb_tid[TW-1:0]);
      end
      n_cmp++;
      if (src_ready !== '1 || obs_bus !== exp_bus) begin
         n_bad++;
         $display("[TB] FAIL squash_ready: got ready=%b expected 111111", src_ready);
      end
      clear_inputs();
      leaked = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (cdb_valid !== 2'b00) leaked++;
      end
      n_cmp++;
      if (leaked != 0) begin
         n_bad++;
         $display("[TB] FAIL squash_leak: got %0d broadcast cycles expected 0", leaked);
      end
      offer(2, 64'h22, 6'd2, 1'b0);
      offer(3, 64'h33, 6'd3, 1'b1);
      offer(5, 64'h55, 6'd5, 1'b0);
      tick();
      src_valid = '0;
      squash = 2'b11;
      tick();
      squash = 2'b00;
      n_cmp++;
      if (cdb_valid !== 2'b00 || src_ready !== '1) begin
         n_bad++;
         $display("[TB] FAIL squash_all: got valid=%b ready=%b expected 00/111111", cdb_valid, src_ready);
      end
   endtask

   task automatic test_reset_mid_drain();
      int leaked;
      do_reset();
      for (int s = 2; s < NS; s++) offer(s, DW'(s), PW'(s), 1'b0);
      tick();
      src_valid = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (cdb_valid !== 2'b00 || src_ready !== '1) begin
         n_bad++;
         $display("[TB] FAIL midreset: got valid=%b ready=%b expected 00/111111", cdb_valid, src_ready);
      end
      leaked = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (cdb_valid !== 2'b00) leaked++;
      end
      n_cmp++;
      if (leaked != 0) begin
         n_bad++;
         $display("[TB] FAIL midreset_leak: got %0d broadcast cycles expected 0", leaked);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         src_valid = NS'($urandom);
         for (int s = 0; s < NS; s++) begin
            src_result[s*DW +: DW] = {$urandom, $urandom};
            src_prn[s*PW +: PW]    = PW'($urandom);
            src_rob[s*RW +: RW]    = RW'($urandom);
            src_tid[s*TW +: TW]    = TW'($urandom);
            src_mispredict[s]      = 1'($urandom);
         end
         squash = ($urandom_range(0, 7) == 0) ? NT'($urandom) : '0;
         reset  = ($urandom_range(0, 49) == 0);
         tick();
         n_cmp++;
         if (obs_bus !== exp_bus) begin
            n_bad++;
            $display("[TB] FAIL random_bus c%0d: got %h expected %h", c, obs_bus, exp_bus);
         end
         n_cmp++;
         if (src_ready !== exp_ready) begin
            n_bad++;
            $display("[TB] FAIL random_ready c%0d: got %b expected %b", c, src_ready, exp_ready);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_source();
      test_full_contention();
      test_starvation();
      test_squash();
      test_reset_mid_drain();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cdb_broadcast_arbiter.md
CDB_BROADCAST_ARBITER -- requirements
Module: cdb_broadcast_arbiter

Interface
REQ-001 The block SHALL have one clock, `clock`; reset is `reset`, synchronous and active-high.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- NUM_SRC, 6, number of result sources.
- NUM_CDB, 2, number of broadcast buses.
- NUM_FIXED, 2, sources 0..NUM_FIXED-1 are fixed-priority (LSQ).
- DATA_W, 64, result width.
- PRN_W, 6, physical register index width.
- ROB_W, 5, ROB index width.
- TID_W, 1, thread ID width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- src_valid, in, NUM_SRC, per-source result offered.
- src_result, in, NUM_SRC*DATA_W, per-source result.
- src_prn, in, NUM_SRC*PRN_W, destination physical register.
- src_rob, in, NUM_SRC*ROB_W, ROB index.
- src_tid, in, NUM_SRC*TID_W, thread ID.
- src_mispredict, in, NUM_SRC, branch mispredict flag.
- squash, in, 2**TID_W, per-thread flush.
- src_ready, out, NUM_SRC, source may offer a result.
- cdb_valid, out, NUM_CDB, bus carries a result.
- cdb_result, out, NUM_CDB*DATA_W, bus result.
- cdb_prn, out, NUM_CDB*PRN_W, bus physical register.
- cdb_rob, out, NUM_CDB*ROB_W, bus ROB index.
- cdb_tid, out, NUM_CDB*TID_W, bus thread ID.
- cdb_mispredict, out, NUM_CDB, bus mispredict flag.

Function
REQ-004 Each source SHALL own a one-entry hold register (valid, result, prn, rob, tid, mispredict).
REQ-005 src_ready[i] SHALL equal NOT hold_valid[i] and SHALL have no combinational path from any input.
REQ-006 When src_valid[i] and src_ready[i] are both high at a clock edge, the hold register SHALL capture the source's fields, unless squash[src_tid[i]] is high.
REQ-007 Each cycle the block SHALL select up to NUM_CDB winners from the valid hold entries, excluding entries whose tid is being squashed.
REQ-008 Fixed-priority sources SHALL win first, with the lowest index winning.
REQ-009 Remaining bus slots SHALL go to sources NUM_FIXED..NUM_SRC-1 in round-robin order, starting at rr_ptr.
REQ-010 CDB ports SHALL be filled in winner order: port 0 takes the highest-priority winner, then port 1, and so on; unused ports SHALL have cdb_valid=0.
REQ-011 CDB outputs SHALL be registered; a winner chosen in cycle k SHALL appear on the CDB for exactly cycle k+1, and its hold_valid SHALL clear at the same edge.
REQ-012 Latency: a result captured at edge e SHALL broadcast no earlier than the cycle after edge e+1, i.e. a minimum of 2 edges from offer to visibility.
REQ-013 rr_ptr SHALL advance to one past the last round-robin source granted, wrapping from NUM_SRC-1 to NUM_FIXED; it SHALL hold when no round-robin source wins.
REQ-014 A loser SHALL keep its entry and hold src_ready low until it is granted; no entry SHALL be dropped except by squash or reset.
REQ-015 squash[t] at an edge SHALL clear every hold entry with tid==t, and SHALL also clear any CDB output register about to load an entry with tid==t.
REQ-016 squash SHALL NOT affect other threads; simultaneous squash of all threads SHALL empty all entries.
REQ-017 If fewer than NUM_CDB entries are valid, all valid entries SHALL win in the same cycle.
REQ-018 The block SHALL support NUM_CDB >= 1, NUM_FIXED from 0 to NUM_SRC, and NUM_SRC up to 16.

Reset
REQ-019 While reset is high at an edge, the block SHALL clear all hold_valid, all cdb_* outputs (to 0) and rr_ptr (to NUM_FIXED); src_ready SHALL then read all ones.
REQ-020 Reset mid-operation SHALL discard all pending and in-flight results without broadcasting them.

Verification
REQ-021 Single source: src 2 offers result 5 (prn 3) -> cdb_valid[0]=1, cdb_result=5, cdb_prn=3 two edges later, for one cycle; src_ready[2] low for exactly one cycle.
REQ-022 Full contention: all 6 sources offer in the same cycle, with LSQ0=0xAAAA and LSQ1=0xBBBB -> the first broadcast is 0xAAAA on port 0 and 0xBBBB on port 1; the ALU/branch/mult results drain two per cycle in round-robin order; all 6 results appear within 3 broadcast cycles with no loss or duplication.
REQ-023 Starvation: LSQ0 offers every cycle and sources 2..5 offer continuously -> each of sources 2..5 is granted once per 4 round-robin grants.
REQ-024 Squash: src 2 (tid 0) and src 3 (tid 1) are held when squash=2'b01 -> src 2 is never broadcast and src 3 broadcasts with tid 1; src_ready[2] returns high the next cycle.
REQ-025 Reset mid-drain: assert reset with 4 entries pending -> all cdb_valid=0 and all src_ready=1 after the reset edge, and nothing is broadcast afterwards.
